// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_detect_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int LEN_W = $clog2(PAT_W_DEF + 1);
  localparam int MASK_W = 32;

  typedef enum logic {
    ST_FILL,
    ST_ARMED
  } state_t;

  function automatic logic [MASK_W-1:0] len_mask(input int len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++)
      if (i < len) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with run-time pattern,
// length and overlap mode; flags each match and counts matches.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W       = 4,
  parameter int             CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1011
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
  input  logic                       din_vld,
  input  logic                       din,
  input  logic                       cnt_clr,
  output logic                       flag,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int LW = $clog2(PAT_W + 1);

  state_t           state, state_d;
  logic [PAT_W-1:0] pat, hist, hist_d, hist_sh, mask;
  logic [LW-1:0]    len, len_ld, fill, fill_d, fill_inc;
  logic             ovl, match;

  assign mask     = PAT_W'(len_mask(int'(len)));
  assign hist_sh  = {hist[PAT_W-2:0], din};
  assign fill_inc = (fill < len) ? fill + LW'(1) : fill;
  assign len_ld   = ((cfg_len == '0) || (cfg_len > LW'(PAT_W)))
                  ? LW'(PAT_W) : cfg_len;

  always_comb begin
    hist_d  = hist;
    fill_d  = fill;
    state_d = state;
    match   = 1'b0;
    if (cfg_load) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (din_vld) begin
      hist_d = hist_sh;
      fill_d = fill_inc;
      match  = (fill_inc >= len) &&
               (((hist_sh ^ pat) & mask) == '0);
      case (state)
        ST_FILL:  if (fill_inc >= len) state_d = ST_ARMED;
        ST_ARMED: state_d = ST_ARMED;
        default:  state_d = ST_FILL;
      endcase
      // Non-overlap: the next match needs len fresh bits.
      if (match && !ovl) begin
        fill_d  = '0;
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat   <= DEFAULT_PAT;
      len   <= LW'(PAT_W);
      ovl   <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      state <= ST_FILL;
      flag  <= 1'b0;
    end else begin
      if (cfg_load) begin
        pat <= cfg_pat;
        len <= len_ld;
        ovl <= cfg_overlap;
      end
      hist  <= hist_d;
      fill  <= fill_d;
      state <= state_d;
      flag  <= match;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (cnt_clr),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench: bit-queue reference model compared every cycle,
// plus literal expectations at key points.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pat = 4'b0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic       din_vld = 1'b0;
  logic       din = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       flag, flag2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_prog #(.PAT_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_vld(din_vld),
    .din(din), .cnt_clr(cnt_clr), .flag(flag), .match_cnt(cnt8)
  );

  seq_detect_prog #(.PAT_W(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_vld(din_vld),
    .din(din), .cnt_clr(cnt_clr), .flag(flag2), .match_cnt(cnt2)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: the received bits since the last restart.
  int m_pat, m_len;
  bit m_ovl;
  bit q[$];
  int e_flag, e_c8, e_c2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pat = 11; m_len = 4; m_ovl = 1'b1;
      q.delete();
      e_flag = 0; e_c8 = 0; e_c2 = 0;
    end else begin
      bit m;
      m = 1'b0;
      if (cfg_load) begin
        m_pat = int'(cfg_pat);
        m_len = (cfg_len == 0 || cfg_len > 4) ? 4 : int'(cfg_len);
        m_ovl = cfg_overlap;
        q.delete();
      end else if (din_vld) begin
        q.push_back(din);
        if (q.size() > 4) void'(q.pop_front());
        if (q.size() >= m_len) begin
          m = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (q[q.size()-1-i] != ((m_pat >> i) & 1)) m = 1'b0;
        end
        if (m && !m_ovl) q.delete();
      end
      e_flag = m;
      if (cnt_clr) begin
        e_c8 = 0; e_c2 = 0;
      end else if (m) begin
        if (e_c8 < 255) e_c8++;
        if (e_c2 < 3) e_c2++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("flag", int'(flag), e_flag);
      chk("flag2", int'(flag2), e_flag);
      chk("cnt8", int'(cnt8), e_c8);
      chk("cnt2", int'(cnt2), e_c2);
    end
  end

  // Drive one cycle at a negedge; return at the next negedge.
  task automatic cyc(input bit v, input bit d, input bit l, input bit c);
    din_vld = v; din = d; cfg_load = l; cnt_clr = c;
    @(negedge clk);
    din_vld = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic send(input bit d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [3:0] p, input logic [2:0] l,
                     input bit o, input bit c);
    cfg_pat = p; cfg_len = l; cfg_overlap = o;
    cyc(1'b1, 1'b1, 1'b1, c);
  endtask

  initial begin
    logic [6:0] s1;
    s1 = 7'b1011011;
    repeat (2) @(negedge clk);
    chk("rst_flag", int'(flag), 0);
    chk("rst_cnt", int'(cnt8), 0);
    rst = 1'b0;

    // 1: defaults, overlap
    for (int i = 6; i >= 0; i--) begin
      send(s1[i]);
      if (i == 3) chk("t1_flag4", int'(flag), 1);
      if (i == 2) chk("t1_flag5", int'(flag), 0);
    end
    chk("t1_flag7", int'(flag), 1);
    chk("t1_cnt", int'(cnt8), 2);

    // 2: non-overlap
    cfg(4'b1011, 3'd4, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) send(s1[i]);
    chk("t2_flag7", int'(flag), 0);
    chk("t2_cnt", int'(cnt8), 1);

    // 3: len 2 with gaps; pattern bit 2 set but masked
    cfg(4'b0111, 3'd2, 1'b1, 1'b0);
    for (int b = 0; b < 3; b++) begin
      send(1'b1);
      if (b >= 1) chk("t3_flag", int'(flag), 1);
      repeat (3) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_gap", int'(flag), 0);
      end
    end

    // 4: len 1, saturation of narrow counter, clear priority
    cfg(4'b1101, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) send(1'b1);
    chk("t4_cnt2", int'(cnt2), 3);
    chk("t4_cnt8", int'(cnt8), 6);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t4_clr_flag", int'(flag), 1);
    chk("t4_clr_cnt", int'(cnt2), 0);

    // 5: load on the final bit; len 0 clamps to 4
    cfg(4'b1011, 3'd0, 1'b1, 1'b0);
    send(1); send(0); send(1);
    cfg(4'b1011, 3'd0, 1'b1, 1'b0);
    chk("t5_noflag", int'(flag), 0);
    send(1); send(0); send(1);
    chk("t5_fill", int'(flag), 0);
    send(1);
    chk("t5_flag", int'(flag), 1);

    // 6: async reset drops flag, forgets partial pattern
    #1 rst = 1'b1;
    #1 chk("t6_async", int'(flag), 0);
    @(negedge clk); rst = 1'b0;
    send(1); send(0); send(1);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send(1);
    chk("t6_forget", int'(flag), 0);
    send(0); send(1); send(1);
    chk("t6_flag", int'(flag), 1);
    chk("t6_cnt", int'(cnt8), 1);
    send(0);
    chk("t6_once", int'(flag), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
